// File: rtl/tradeoff_w_driver.sv
// tradeoff_w_driver: FIFO-buffered operand driver and result checker for a Tradeoff search engine.
// Optional WAIT_FOUND watchdog enabled by defining TRADEOFF_DRV_TIMEOUT_EN.
module tradeoff_w_driver #(
    parameter int W_BITS   = 25,
    parameter int N_BITS   = 13,
    parameter int EXP_N    = 4095,
    parameter int DEPTH    = 4,
    parameter int GUARD    = 2,
    parameter int SETTLE   = 1,
    parameter int TIMEOUT  = 4096,
    parameter int CNT_BITS = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [W_BITS-1:0]   in_w,
    output logic [W_BITS-1:0]   eng_w,
    input  logic                eng_found,
    input  logic [N_BITS-1:0]   eng_n,
    output logic                res_valid,
    output logic [W_BITS-1:0]   res_w,
    output logic [N_BITS-1:0]   res_n,
    output logic                res_pass,
    output logic                res_timeout,
    input  logic                cnt_clr,
    output logic [CNT_BITS-1:0] total_cnt,
    output logic [CNT_BITS-1:0] err_cnt,
    output logic                busy
);
    localparam int AW = $clog2(DEPTH);
    localparam int GS = (GUARD > SETTLE) ? GUARD : SETTLE;
    localparam int TMAX = (TIMEOUT > GS) ? TIMEOUT : GS;
    localparam int TW = $clog2(TMAX + 1);
    localparam logic [N_BITS-1:0] EXP = N_BITS'(EXP_N);
    localparam logic [CNT_BITS-1:0] CMAX = '1;

    typedef enum logic [2:0] {S_IDLE, S_APPLY, S_WAIT, S_SETTLE, S_REPORT} state_t;

    state_t state;
    logic [W_BITS-1:0] mem [DEPTH];
    logic [AW-1:0] wp, rp;
    logic [AW:0] cnt;
    logic [TW-1:0] tmr;
    logic push, pop;

    assign in_ready = cnt != (AW+1)'(DEPTH);
    assign push = in_valid && in_ready;
    assign pop = state == S_IDLE && cnt != '0;
    assign busy = state != S_IDLE;

    always_ff @(posedge clk) begin
        if (push) mem[wp] <= in_w;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp <= '0;
            rp <= '0;
            cnt <= '0;
        end else begin
            if (push) wp <= wp + AW'(1);
            if (pop) rp <= rp + AW'(1);
            cnt <= cnt + (AW+1)'(push) - (AW+1)'(pop);
        end
    end

    // tmr is shared: guard window in APPLY, settle count, and watchdog in WAIT
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            tmr <= '0;
            eng_w <= '0;
            res_w <= '0;
            res_n <= '0;
            res_valid <= 1'b0;
            res_pass <= 1'b0;
            res_timeout <= 1'b0;
        end else begin
            res_valid <= 1'b0;
            tmr <= tmr + TW'(1);
            case (state)
                S_IDLE: if (pop) begin
                    eng_w <= mem[rp];
                    res_w <= mem[rp];
                    res_timeout <= 1'b0;
                    tmr <= '0;
                    state <= S_APPLY;
                end
                S_APPLY: if (tmr == TW'(GUARD - 1)) begin
                    tmr <= '0;
                    state <= S_WAIT;
                end
                S_WAIT: if (eng_found) begin
                    tmr <= '0;
                    state <= S_SETTLE;
                end
`ifdef TRADEOFF_DRV_TIMEOUT_EN
                else if (tmr == TW'(TIMEOUT - 1)) begin
                    res_n <= '0;
                    res_timeout <= 1'b1;
                    res_pass <= 1'b0;
                    res_valid <= 1'b1;
                    state <= S_REPORT;
                end
`endif
                S_SETTLE: if (tmr == TW'(SETTLE - 1)) begin
                    res_n <= eng_n;
                    res_pass <= eng_n == EXP;
                    res_valid <= 1'b1;
                    state <= S_REPORT;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // counters update as REPORT ends, so a coincident clear drops that increment
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            total_cnt <= '0;
            err_cnt <= '0;
        end else if (cnt_clr) begin
            total_cnt <= '0;
            err_cnt <= '0;
        end else if (state == S_REPORT) begin
            if (total_cnt != CMAX) total_cnt <= total_cnt + CNT_BITS'(1);
            if (!res_pass && err_cnt != CMAX) err_cnt <= err_cnt + CNT_BITS'(1);
        end
    end
endmodule
